// File: rtl/drum_sample_player_if.sv
// drum_sample_player_if
// Avalon read-only bus between the drum sample player and its on-chip sample RAM.
// Ports (signals):
//   mem_address    - RAM word address (driven by the player, registered)
//   mem_chipselect - read strobe
//   mem_clken      - RAM clock enable
//   mem_readdata   - RAM q, valid one clock after the address is registered by the RAM
// Modports: master = player side, slave = RAM side.
interface drum_sample_player_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    modport master (
        output mem_address,
        output mem_chipselect,
        output mem_clken,
        input  mem_readdata
    );

    modport slave (
        input  mem_address,
        input  mem_chipselect,
        input  mem_clken,
        output mem_readdata
    );
endinterface

// File: rtl/drum_sample_player.sv
// drum_sample_player
// Plays one signed PCM drum sample out of a single-port RAM, one word per audio tick.
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   trigger       - start / restart playback from word 0
//   sample_tick   - audio-rate strobe; each tick yields one sample_valid 3 clocks later
//   atten         - arithmetic right shift applied to each sample
//   mem           - Avalon master port to the sample RAM
//   sample_out    - current output sample (held between updates)
//   sample_valid  - one-cycle pulse when sample_out updates
//   busy          - playback in progress
//   done          - one-cycle pulse alongside the final sample
module drum_sample_player #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_WORDS = 6778
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trigger,
    input  logic                     sample_tick,
    input  logic [3:0]               atten,
    drum_sample_player_if.master     mem,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StRead, StCapture} state_e;

    state_e                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W-1:0]        mem_address_q;
    logic                     mem_chipselect_q;
    logic                     mem_clken_q;
    logic signed [DATA_W-1:0] sample_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;
    // Delays an idle tick so silence appears with the same 3-clock latency as a real read.
    logic [1:0]               idle_pipe_q;

    logic signed [DATA_W-1:0] rdata_s;
    logic signed [DATA_W-1:0] shifted;

    always_comb begin
        rdata_s = mem.mem_readdata;
        shifted = rdata_s >>> atten;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StIdle;
            addr_q           <= '0;
            mem_address_q    <= '0;
            mem_chipselect_q <= 1'b0;
            mem_clken_q      <= 1'b0;
            sample_q         <= '0;
            valid_q          <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            idle_pipe_q      <= '0;
        end else begin
            mem_clken_q      <= 1'b1;
            mem_chipselect_q <= 1'b0;
            valid_q          <= 1'b0;
            done_q           <= 1'b0;
            idle_pipe_q      <= {idle_pipe_q[0], sample_tick & (state_q == StIdle)};

            if (trigger) begin
                // Restart wins over everything; any pending read or silence is dropped.
                addr_q      <= '0;
                busy_q      <= 1'b1;
                state_q     <= StArmed;
                idle_pipe_q <= '0;
            end else begin
                if (idle_pipe_q[1]) begin
                    sample_q <= '0;
                    valid_q  <= 1'b1;
                end
                unique case (state_q)
                    StIdle: ;
                    StArmed: begin
                        if (sample_tick) begin
                            mem_address_q    <= addr_q;
                            mem_chipselect_q <= 1'b1;
                            state_q          <= StRead;
                        end
                    end
                    StRead: begin
                        state_q <= StCapture;
                    end
                    StCapture: begin
                        sample_q <= shifted;
                        valid_q  <= 1'b1;
                        if (addr_q == LastAddr) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= StArmed;
                        end
                    end
                endcase
            end
        end
    end

    assign mem.mem_address    = mem_address_q;
    assign mem.mem_chipselect = mem_chipselect_q;
    assign mem.mem_clken      = mem_clken_q;
    assign sample_out         = sample_q;
    assign sample_valid       = valid_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_drum_sample_player.sv
// tb_drum_sample_player
// Self-checking bench for drum_sample_player: behavioural sample RAM, a scoreboard of
// expected {sample, done, busy, cycle} entries pushed per tick, a vector table for
// attenuation, and hand-written sequences for retrigger, tick collisions and reset.
module tb_drum_sample_player;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 6778;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          trigger = 1'b0;
    logic          sample_tick = 1'b0;
    logic [3:0]    atten = 4'd0;
    logic [DW-1:0] sample_out;
    logic          sample_valid;
    logic          busy;
    logic          done;

    drum_sample_player_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    drum_sample_player #(.ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trigger      (trigger),
        .sample_tick  (sample_tick),
        .atten        (atten),
        .mem          (bus),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Sample RAM: registered address, unregistered q.
    logic [DW-1:0] ram [8192];
    logic [AW-1:0] ram_addr_q = '0;
    always @(posedge clk) if (bus.mem_clken) ram_addr_q <= bus.mem_address;
    assign bus.mem_readdata = ram[ram_addr_q];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cs_count = 0;
    always @(negedge clk) if (bus.mem_chipselect) cs_count++;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [DW-1:0] s;
        logic          dn;
        logic          bsy;
        int unsigned   cyc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (sample_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got sample %h, expected no sample_valid (cycle %0d)",
                         sample_out, cyc);
            end else begin
                e = sb.pop_front();
                check("sample_done_busy", {15'd0, sample_out, done, busy}, {15'd0, e.s, e.dn, e.bsy});
                check("latency", cyc, e.cyc);
            end
        end else begin
            if (done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_without_valid: got done=1, expected 0 (cycle %0d)", cyc);
            end
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_valid: got none, expected sample %h at cycle %0d", e.s, e.cyc);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_raw();
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic tick_exp(input logic [DW-1:0] s, input logic dn, input logic bsy);
        exp_t e;
        e.s   = s;
        e.dn  = dn;
        e.bsy = bsy;
        e.cyc = cyc + 3;
        sb.push_back(e);
        tick_raw();
    endtask

    task automatic do_trigger();
        trigger = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] word;
        logic [3:0]    att;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    int cs0;

    initial begin
        tbl[0] = '{16'h8000, 4'd4,  16'hF800};
        tbl[1] = '{16'h7FFF, 4'd4,  16'h07FF};
        tbl[2] = '{16'h1234, 4'd0,  16'h1234};
        tbl[3] = '{16'h8000, 4'd15, 16'hFFFF};
        tbl[4] = '{16'h7FFF, 4'd15, 16'h0000};
        tbl[5] = '{16'hFFFF, 4'd1,  16'hFFFF};
        tbl[6] = '{16'h0100, 4'd3,  16'h0020};
        tbl[7] = '{16'hC000, 4'd2,  16'hF000};
        for (int i = 0; i < 8192; i++) ram[i] = 16'(i);

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check("rst_address", 32'(bus.mem_address), 0);
        check("rst_chipselect", 32'(bus.mem_chipselect), 0);
        check("rst_clken", 32'(bus.mem_clken), 0);
        check("rst_sample_out", 32'(sample_out), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_clks(2);
        check("clken_after_reset", 32'(bus.mem_clken), 1);

        // Idle tick: silence, no RAM access
        cs0 = cs_count;
        tick_exp(16'h0000, 1'b0, 1'b0);
        wait_clks(5);
        check("idle_no_read", cs_count, cs0);

        // Attenuation table
        for (int i = 0; i < 8; i++) ram[i] = tbl[i].word;
        do_trigger();
        check("busy_after_trigger", 32'(busy), 1);
        wait_clks(2);
        for (int i = 0; i < 8; i++) begin
            atten = tbl[i].att;
            tick_exp(tbl[i].exp, 1'b0, 1'b1);
            wait_clks(5);
        end
        atten = 4'd0;

        // Full playback of word[i] = i
        for (int i = 0; i < 8192; i++) ram[i] = 16'(i);
        do_trigger();
        wait_clks(2);
        for (int i = 0; i < int'(NW); i++) begin
            tick_exp(16'(i), i == int'(NW) - 1, i != int'(NW) - 1);
            wait_clks(4);
        end
        wait_clks(2);
        check("busy_after_done", 32'(busy), 0);
        tick_exp(16'h0000, 1'b0, 1'b0);
        wait_clks(5);

        // Retrigger while a capture is pending
        do_trigger();
        wait_clks(2);
        for (int i = 0; i < 100; i++) begin
            tick_exp(16'(i), 1'b0, 1'b1);
            wait_clks(4);
        end
        tick_raw();
        wait_clks(1);
        do_trigger();
        check("busy_on_retrigger", 32'(busy), 1);
        wait_clks(4);
        tick_exp(16'h0000, 1'b0, 1'b1);
        wait_clks(4);
        check("busy_after_retrigger", 32'(busy), 1);

        // Trigger and tick together in ARMED
        tick_exp(16'h0001, 1'b0, 1'b1);
        wait_clks(4);
        tick_exp(16'h0002, 1'b0, 1'b1);
        wait_clks(4);
        cs0 = cs_count;
        trigger = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        trigger = 1'b0;
        sample_tick = 1'b0;
        wait_clks(4);
        check("simul_no_read", cs_count, cs0);
        tick_exp(16'h0000, 1'b0, 1'b1);
        wait_clks(4);

        // Tick 2 clocks after the previous one is ignored
        cs0 = cs_count;
        tick_exp(16'h0001, 1'b0, 1'b1);
        wait_clks(1);
        tick_raw();
        wait_clks(5);
        check("violation_one_read", cs_count, cs0 + 1);
        tick_exp(16'h0002, 1'b0, 1'b1);
        wait_clks(5);

        // Asynchronous reset mid-play
        do_trigger();
        wait_clks(2);
        for (int i = 0; i < 500; i++) begin
            tick_exp(16'(i), 1'b0, 1'b1);
            wait_clks(4);
        end
        tick_raw();
        wait_clks(1);
        cs0 = cs_count;
        #2 reset_n = 1'b0;
        #1;
        check("async_sample_out", 32'(sample_out), 0);
        check("async_busy", 32'(busy), 0);
        check("async_valid", 32'(sample_valid), 0);
        check("async_done", 32'(done), 0);
        check("async_address", 32'(bus.mem_address), 0);
        check("async_chipselect", 32'(bus.mem_chipselect), 0);
        check("async_clken", 32'(bus.mem_clken), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_clks(2);
        tick_exp(16'h0000, 1'b0, 1'b0);
        wait_clks(6);
        check("no_read_after_reset", cs_count, cs0);
        check("busy_after_reset", 32'(busy), 0);

        wait_clks(4);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
